// File: rtl/step_dir_generator.sv
// step_dir_generator
// Command-driven step/direction pulse source feeding a stepper phase driver.
// A move command (step count, direction, step period) is taken over a
// valid/ready handshake. The generator then waits DIR_SETUP_CYC cycles with
// the new direction applied, emits the requested number of PULSE_HIGH_CYC
// wide pulses spaced eff_period cycles apart (rising edge to rising edge),
// tracks a signed absolute position and signals done (with aborted when the
// move was cut short).
//
// Handshake: a command transfers on the rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only while the generator is idle. The
// source must hold cmd_steps/cmd_dir/cmd_period stable while cmd_valid is 1
// and cmd_ready is 0.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake
//   cmd_steps          unsigned step count (0 = finish immediately)
//   cmd_dir            1 = forward (+1 per step), 0 = reverse (-1 per step)
//   cmd_period         step period in cycles, clamped to PULSE_HIGH_CYC+1
//   abort              end the current move cleanly
//   rotate_pulse       registered step pulse
//   direction          registered direction, held until the next accept
//   busy               move in progress (includes the done cycle)
//   done, aborted      one-cycle end-of-command pulse and its abort flag
//   position           signed absolute position, wraps modulo 2^POS_W
//   steps_remaining    steps not yet issued
//   fsm_state          current FSM state for observation
module step_dir_generator #(
  parameter int CNT_W          = 16,
  parameter int PER_W          = 16,
  parameter int POS_W          = 32,
  parameter int DIR_SETUP_CYC  = 27,
  parameter int PULSE_HIGH_CYC = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             rotate_pulse,
  output logic             direction,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position,
  output logic [CNT_W-1:0] steps_remaining,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DIR_SETUP  = 3'd1,
    PULSE_HIGH = 3'd2,
    PULSE_LOW  = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam int TMR_W = 32;
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] HIGH_LOAD  = TMR_W'(PULSE_HIGH_CYC - 1);
  localparam logic [PER_W-1:0] MIN_PERIOD = PER_W'(PULSE_HIGH_CYC + 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [PER_W-1:0] eff_period;
  logic             abort_pend;
  logic             accept;
  logic             end_by_abort;
  logic             step_issue;

  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign fsm_state = state;

  // A step is issued on entry to PULSE_HIGH; position and steps_remaining
  // change together with the rising edge of rotate_pulse.
  assign step_issue = (state_nxt == PULSE_HIGH) && (state != PULSE_HIGH);

  always_comb begin
    state_nxt    = state;
    end_by_abort = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (cmd_steps == '0) ? DONE : DIR_SETUP;
        end
      end
      DIR_SETUP: begin
        if (abort) begin
          state_nxt    = DONE;
          end_by_abort = 1'b1;
        end else if (tmr == '0) begin
          state_nxt = PULSE_HIGH;
        end
      end
      PULSE_HIGH: begin
        // An abort seen during the high phase is remembered so the pulse
        // keeps its full width; the low phase is then skipped.
        if (tmr == '0) begin
          if (abort || abort_pend) begin
            state_nxt    = DONE;
            end_by_abort = 1'b1;
          end else begin
            state_nxt = PULSE_LOW;
          end
        end
      end
      PULSE_LOW: begin
        if (abort) begin
          state_nxt    = DONE;
          end_by_abort = 1'b1;
        end else if (tmr == '0) begin
          state_nxt = (steps_remaining != '0) ? PULSE_HIGH : DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Phase timer: loaded with (length-1) on entry to a timed state, counts
  // down to zero on the last cycle of that state.
  always_comb begin
    tmr_nxt = '0;
    if (state_nxt != state) begin
      unique case (state_nxt)
        DIR_SETUP:  tmr_nxt = SETUP_LOAD;
        PULSE_HIGH: tmr_nxt = HIGH_LOAD;
        PULSE_LOW:  tmr_nxt = TMR_W'(eff_period) - TMR_W'(PULSE_HIGH_CYC + 1);
        default:    tmr_nxt = '0;
      endcase
    end else if (tmr != '0) begin
      tmr_nxt = tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_pend <= 1'b0;
    end else begin
      abort_pend <= (state == PULSE_HIGH) && (state_nxt == PULSE_HIGH) &&
                    (abort || abort_pend);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_period      <= MIN_PERIOD;
      direction       <= 1'b0;
      position        <= '0;
      steps_remaining <= '0;
    end else if (accept) begin
      eff_period      <= (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
      direction       <= cmd_dir;
      steps_remaining <= cmd_steps;
    end else if (step_issue) begin
      position        <= direction ? position + POS_W'(1) : position - POS_W'(1);
      steps_remaining <= steps_remaining - CNT_W'(1);
    end
  end

  // Status outputs are registered from the next state so they line up with
  // the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rotate_pulse <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cmd_ready    <= 1'b1;
    end else begin
      rotate_pulse <= (state_nxt == PULSE_HIGH);
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == DONE);
      aborted      <= (state_nxt == DONE) && end_by_abort;
      cmd_ready    <= (state_nxt == IDLE);
    end
  end

endmodule
